// File: rtl/tick_stopwatch_pkg.sv
// Shared definitions for the tick_stopwatch block: FSM encodings, digit width
// and the all-nines terminal value helper.
package tick_stopwatch_pkg;

    localparam int unsigned DigitW    = 4;
    localparam int unsigned MaxDigits = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;
    localparam logic [1:0] StOvf  = 2'd3;

    // BCD value with the lowest `digits` digits at 9, upper digits zero.
    function automatic logic [DigitW*MaxDigits-1:0] all_nines(input int unsigned digits);
        logic [DigitW*MaxDigits-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxDigits; i++) begin
            if (i < digits) begin
                v[i*DigitW +: DigitW] = DigitW'(9);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_stopwatch_digit.sv
// bcd_digit: one registered BCD digit with increment, synchronous clear and
// ripple carry-out. Chained by tick_stopwatch to form the multi-digit count.
module bcd_digit
    import tick_stopwatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [DigitW-1:0] q,
    output logic              carry_out
);

    logic [DigitW-1:0] q_q;
    logic [DigitW-1:0] q_d;

    assign q         = q_q;
    assign carry_out = inc && (q_q == DigitW'(9));

    // Next digit value: clear wins, otherwise count 0..9 on inc.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == DigitW'(9)) ? '0 : q_q + DigitW'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/tick_stopwatch.sv
// tick_stopwatch: start/stop/clear BCD stopwatch driven by a one-cycle time-base
// tick. A prescaler turns TICKS_PER_UNIT ticks into one BCD increment; a small
// FSM (IDLE/RUN/HOLD/OVF) gates counting.
// Optional comparator: define TICK_STOPWATCH_MATCH_EN to build the match pulse;
// otherwise match is tied low and match_val is ignored.
module tick_stopwatch
    import tick_stopwatch_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TICKS_PER_UNIT = 10,
    parameter int unsigned WRAP           = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    tick_in,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic [4*DIGITS-1:0]     match_val,
    output logic [4*DIGITS-1:0]     bcd,
    output logic                    running,
    output logic                    overflow,
    output logic                    match
);

    localparam int unsigned BcdW  = DigitW * DIGITS;
    localparam int unsigned PresW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PresW-1:0] PresLast = PresW'(TICKS_PER_UNIT - 1);
    localparam logic [DigitW*MaxDigits-1:0] NinesFull = all_nines(DIGITS);
    localparam logic [BcdW-1:0] BcdNines = NinesFull[BcdW-1:0];

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [PresW-1:0] pres_q;
    logic [PresW-1:0] pres_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             tick_en;
    logic             pres_wrap;
    logic             terminal;
    logic             digit_inc;
    logic [DIGITS:0]  carry;
    logic             unused_carry;

    // A tick counts only in RUN and never on an edge carrying clear or stop.
    assign tick_en   = (state_q == StRun) && !clear && !stop && tick_in;
    assign pres_wrap = tick_en && (pres_q == PresLast);
    assign terminal  = (bcd == BcdNines);
    // Saturating build holds all-nines instead of rolling over.
    assign digit_inc = pres_wrap && ((WRAP != 0) || !terminal);

    assign carry[0]     = digit_inc;
    assign unused_carry = carry[DIGITS];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk       (sys_clk),
                .rst_n     (sys_rst_n),
                .inc       (carry[g]),
                .clr       (clear),
                .q         (bcd[g*DigitW +: DigitW]),
                .carry_out (carry[g+1])
            );
        end
    endgenerate

    // Control FSM; clear > stop > start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StHold: begin
                    if (!stop && start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StHold;
                    end else if (pres_wrap && terminal && (WRAP == 0)) begin
                        state_d = StOvf;
                    end
                end
                StOvf:   state_d = StOvf;
                default: state_d = StIdle;
            endcase
        end
    end

    // Prescaler over 0..TICKS_PER_UNIT-1, advanced by counted ticks only.
    always_comb begin
        pres_d = pres_q;
        if (clear) begin
            pres_d = '0;
        end else if (tick_en) begin
            pres_d = pres_wrap ? '0 : pres_q + PresW'(1);
        end
    end

    // Sticky overflow: set by any increment at terminal count.
    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (pres_wrap && terminal) begin
            ovf_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            pres_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pres_q  <= pres_d;
            ovf_q   <= ovf_d;
        end
    end

    assign running  = (state_q == StRun);
    assign overflow = ovf_q;

`ifdef TICK_STOPWATCH_MATCH_EN
    logic bcd_chg_q;
    logic bcd_chg_d;
    logic match_q;
    logic match_d;
    logic val_ok;

    // Flag that bcd took a new value at the last edge, so match fires only when
    // bcd becomes equal, not when match_val moves onto an unchanged bcd.
    always_comb begin
        bcd_chg_d = clear ? (bcd != '0) : digit_inc;
    end

    // Reject compare values containing a non-decimal digit.
    always_comb begin
        val_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (match_val[i*DigitW +: DigitW] > DigitW'(9)) begin
                val_ok = 1'b0;
            end
        end
    end

    // One-cycle pulse the cycle after bcd becomes equal to match_val.
    always_comb begin
        match_d = bcd_chg_q && val_ok && (bcd == match_val);
    end

    // Comparator registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bcd_chg_q <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            bcd_chg_q <= bcd_chg_d;
            match_q   <= match_d;
        end
    end

    assign match = match_q;
`else
    logic unused_match_val;

    assign unused_match_val = ^match_val;
    assign match            = 1'b0;
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed bench for tick_stopwatch: a default instance (4 digits, 10 ticks per
// unit, saturating) plus two 2-digit, 1-tick-per-unit instances that share
// stimulus and differ only in WRAP.
module tb_tick_stopwatch;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        start;
    logic        stop;
    logic        clear;
    logic [15:0] match_val;
    logic [15:0] bcd;
    logic        running;
    logic        overflow;
    logic        match;

    logic        w_tick;
    logic        w_start;
    logic        w_clear;
    logic [7:0]  s_bcd;
    logic [7:0]  r_bcd;
    logic        s_run;
    logic        s_ovf;
    logic        r_run;
    logic        r_ovf;
    logic        unused_s_match;
    logic        unused_r_match;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

`ifdef TICK_STOPWATCH_MATCH_EN
    localparam logic MatchEn = 1'b1;
`else
    localparam logic MatchEn = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tick_stopwatch #(
        .DIGITS         (4),
        .TICKS_PER_UNIT (10),
        .WRAP           (0)
    ) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .tick_in   (tick),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .match_val (match_val),
        .bcd       (bcd),
        .running   (running),
        .overflow  (overflow),
        .match     (match)
    );

    tick_stopwatch #(
        .DIGITS         (2),
        .TICKS_PER_UNIT (1),
        .WRAP           (0)
    ) u_sat (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .tick_in   (w_tick),
        .start     (w_start),
        .stop      (1'b0),
        .clear     (w_clear),
        .match_val (8'h00),
        .bcd       (s_bcd),
        .running   (s_run),
        .overflow  (s_ovf),
        .match     (unused_s_match)
    );

    tick_stopwatch #(
        .DIGITS         (2),
        .TICKS_PER_UNIT (1),
        .WRAP           (1)
    ) u_wrap (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .tick_in   (w_tick),
        .start     (w_start),
        .stop      (1'b0),
        .clear     (w_clear),
        .match_val (8'h00),
        .bcd       (r_bcd),
        .running   (r_run),
        .overflow  (r_ovf),
        .match     (unused_r_match)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic w_ticks(input int n);
        w_tick = 1'b1;
        repeat (n) step();
        w_tick = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
        match_val = 16'h0A00;
        w_tick    = 1'b0;
        w_start   = 1'b0;
        w_clear   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_match", 32'(match), 32'h0);
        rst_n = 1'b1;
        step();

        // Start, 100 ticks at 10 ticks/unit -> 10 units
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_running_after_start", 32'(running), 32'h1);
        ticks(100);
        check("t1_bcd", 32'(bcd), 32'h0010);
        check("t1_running", 32'(running), 32'h1);
        check("t1_overflow", 32'(overflow), 32'h0);

        // Run 25, stop (with tick), 7 held ticks, start (with tick), 5 more
        clear     = 1'b1;
        match_val = 16'h0003;
        step();
        clear = 1'b0;
        check("t2_clear_bcd", 32'(bcd), 32'h0);
        check("t2_clear_running", 32'(running), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        ticks(25);
        check("t2_bcd_25", 32'(bcd), 32'h0002);
        stop = 1'b1;
        tick = 1'b1;
        step();
        stop = 1'b0;
        tick = 1'b0;
        check("t2_hold_running", 32'(running), 32'h0);
        ticks(7);
        check("t2_hold_bcd", 32'(bcd), 32'h0002);
        start = 1'b1;
        tick  = 1'b1;
        step();
        start = 1'b0;
        tick  = 1'b0;
        check("t2_resume_running", 32'(running), 32'h1);
        ticks(4);
        check("t2_bcd_pre", 32'(bcd), 32'h0002);
        ticks(1);
        check("t2_bcd_3", 32'(bcd), 32'h0003);
        check("t2_match_same_cycle", 32'(match), 32'h0);
        step();
        check("t2_match_pulse", 32'(match), 32'(MatchEn));
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t2_match_drop", 32'(match), 32'h0);
        repeat (3) step();
        check("t2_match_hold", 32'(match), 32'h0);
        check("t2_bcd_hold", 32'(bcd), 32'h0003);

        // Same-edge clear+stop+start at 0x0042
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        ticks(420);
        check("t3_bcd_42", 32'(bcd), 32'h0042);
        clear = 1'b1;
        stop  = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        check("t3_bcd_cleared", 32'(bcd), 32'h0);
        check("t3_running", 32'(running), 32'h0);
        ticks(20);
        check("t3_idle_ignores_ticks", 32'(bcd), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_run_again", 32'(running), 32'h1);
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        check("t3_stop_beats_start", 32'(running), 32'h0);

        // 2-digit saturate vs wrap, one unit per tick
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        check("t4_sat_running", 32'(s_run), 32'h1);
        check("t4_wrap_running", 32'(r_run), 32'h1);
        w_ticks(99);
        check("t4_sat_bcd_99", 32'(s_bcd), 32'h99);
        check("t4_wrap_bcd_99", 32'(r_bcd), 32'h99);
        check("t4_sat_ovf_pre", 32'(s_ovf), 32'h0);
        w_ticks(1);
        check("t4_sat_bcd_hold", 32'(s_bcd), 32'h99);
        check("t4_sat_ovf", 32'(s_ovf), 32'h1);
        check("t4_sat_not_running", 32'(s_run), 32'h0);
        check("t4_wrap_bcd_0", 32'(r_bcd), 32'h00);
        check("t4_wrap_ovf", 32'(r_ovf), 32'h1);
        check("t4_wrap_running", 32'(r_run), 32'h1);
        w_ticks(3);
        check("t4_sat_ignores_ticks", 32'(s_bcd), 32'h99);
        check("t4_wrap_bcd_3", 32'(r_bcd), 32'h03);
        check("t4_wrap_ovf_sticky", 32'(r_ovf), 32'h1);
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        check("t4_ovf_ignores_start", 32'(s_run), 32'h0);
        w_clear = 1'b1;
        step();
        w_clear = 1'b0;
        check("t4_sat_clr_bcd", 32'(s_bcd), 32'h0);
        check("t4_sat_clr_ovf", 32'(s_ovf), 32'h0);
        check("t4_wrap_clr_bcd", 32'(r_bcd), 32'h0);
        check("t4_wrap_clr_ovf", 32'(r_ovf), 32'h0);
        check("t4_wrap_clr_running", 32'(r_run), 32'h0);

        // Async reset mid-run at 0x0017
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        ticks(170);
        check("t5_bcd_17", 32'(bcd), 32'h0017);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_bcd", 32'(bcd), 32'h0);
        check("t5_async_running", 32'(running), 32'h0);
        check("t5_async_overflow", 32'(overflow), 32'h0);
        check("t5_async_match", 32'(match), 32'h0);
        step();
        rst_n = 1'b1;
        ticks(20);
        check("t5_no_start_bcd", 32'(bcd), 32'h0);
        check("t5_no_start_running", 32'(running), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_stopwatch.md
# tick_stopwatch

Downstream consumer of the mod-100 tick counter: takes its one-cycle `dout` pulse (one pulse per 100 `sys_clk` cycles) as a time-base enable and accumulates it into a start/stop/clear BCD stopwatch. A prescaler divides ticks into display units, and a control FSM gates counting. The BCD value drives the display/LED stage; an optional comparator flags a programmed time.

## Interface
- `DIGITS`, 4: number of BCD digits (1–8).
- `TICKS_PER_UNIT`, 10: input ticks per BCD increment (≥1).
- `WRAP`, 0: 1 = roll 99..9 → 0 and continue; 0 = saturate at all-9s and enter OVF.
- `sys_clk` in 1: system clock; all state on rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `tick_in` in 1: one-cycle time-base pulse from the tick counter's `dout`.
- `start` in 1: level-sampled; begin/resume counting.
- `stop` in 1: level-sampled; pause counting.
- `clear` in 1: level-sampled; zero value and prescaler, return to IDLE.
- `match_val` in 4*DIGITS: BCD compare value (digit 0 in bits [3:0]).
- `bcd` out 4*DIGITS: current BCD count, registered.
- `running` out 1: high in RUN.
- `overflow` out 1: sticky; set on first wrap or saturation, cleared only by `clear`/reset.
- `match` out 1: one-cycle pulse when `bcd` becomes equal to `match_val`.

## Operation
- Reset values: `bcd`=0, prescaler=0, state=IDLE, `running`=0, `overflow`=0, `match`=0.
- FSM states:
  - IDLE: value zero, not counting. `start` → RUN.
  - RUN: counting. `stop` → HOLD. At terminal count with WRAP=0 → OVF.
  - HOLD: value and prescaler retained. `start` → RUN.
  - OVF: `bcd` held at all-9s, ticks ignored. Only `clear` leaves (→ IDLE).
- Command priority in one cycle: `clear` > `stop` > `start`. `clear` from any state → IDLE, zeroes `bcd` and prescaler, drops `overflow`.
- Prescaler counts `tick_in` pulses only in RUN, over 0..TICKS_PER_UNIT-1. A tick at TICKS_PER_UNIT-1 resets it to 0 and increments `bcd` by one.
- BCD increment uses per-digit carry. A digit at 9 with carry-in becomes 0 and carries out; other digits are unaffected.
- Terminal count (all digits 9) with an increment:
  - WRAP=1: `bcd` → 0, `overflow` set, stay in RUN.
  - WRAP=0: `bcd` stays all-9s, `overflow` set, → OVF.
- `tick_in` outside RUN is ignored and does not touch the prescaler.
- `match_val` digits >9 never match. There is no error flag.

## Timing
- Commands sampled at edge N change state at edge N. `running` is valid after edge N.
- A `tick_in` sampled at the same edge as the `start` that leaves IDLE/HOLD is not counted. A tick at the same edge as `stop` in RUN is not counted.
- Increment latency: the terminal prescaler tick sampled at edge N gives new `bcd` visible after edge N.
- `match` asserts the cycle after `bcd` takes the equal value, for exactly one cycle. It does not re-fire while `bcd` stays equal. It fires again after `clear`+recount, or after a wrap. A `match_val` change while `bcd` is already equal does not fire.
- Async reset mid-count: all outputs return to reset values immediately. Counting resumes only after a `start` following deassertion.

## Configuration
- `TICK_STOPWATCH_MATCH_EN` defined: comparator and `match` register are built as specified.
- Not defined: `match` is tied to 0, `match_val` is unused, and no comparator logic is synthesized. Other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state encoding constants: IDLE=2'd0, RUN=2'd1, HOLD=2'd2, OVF=2'd3.
  - BCD digit width constant (4).
  - All-nines terminal value helper.
- Sub-module `bcd_digit`: one 4-bit digit with `inc`/`clr` inputs and `carry_out`, instantiated DIGITS times in a generate loop.
- Prescaler and FSM live in the top module.

## Test plan
- Reset then `start`, 100 `tick_in` pulses (TICKS_PER_UNIT=10) → `bcd`=0x0010, `running`=1, `overflow`=0.
- RUN, 25 ticks, `stop`, 7 ticks, `start`, 5 ticks → `bcd`=0x0003 with prescaler retained across HOLD; the ticks during HOLD are ignored.
- Same edge: `clear`+`stop`+`start` while `bcd`=0x0042 → next cycle `bcd`=0, state IDLE, `running`=0.
- WRAP=0, DIGITS=2, preload to 0x99 by counting, one more unit → `bcd`=0x99, `overflow`=1, state OVF, further ticks ignored. With WRAP=1 → `bcd`=0x00, `overflow`=1, still RUN.
- Macro on, `match_val`=0x0003, count to 3 → single `match` pulse one cycle after `bcd`=0x0003, none while held in HOLD. Macro off → `match` stays 0.
- Assert `sys_rst_n` low asynchronously mid-RUN at `bcd`=0x0017 → all outputs 0 without a clock edge. After release, ticks without `start` leave `bcd`=0.
